// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues one-outstanding
//            requests to instruction memory (req/rvalid handshake, zero-wait
//            or multi-cycle), buffers the instruction while IF/ID is stalled
//            and applies ID-stage branch/jump redirects after the delay slot.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            en_if                - IF/ID load enable (stall when 0)
//            redirect_valid/_pc   - taken branch/jump target from ID
//            imem_req/_addr       - fetch request and word address
//            imem_rvalid/_rdata   - fetch response (may be same-cycle)
//            instr_if, pc4_if     - instruction and PC+4 to IF/ID
//            pc_if, valid_if      - current fetch PC, instruction valid
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_if,
  output logic [31:0] pc4_if,
  output logic [31:0] pc_if,
  output logic        valid_if
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,   // request outstanding
    S_HOLD = 1'b1    // instruction buffered, downstream stalled
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr_buf;
  logic [31:0] w_instr_buf_nxt;
  logic        r_pend_valid;
  logic        w_pend_valid_nxt;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_nxt;

  logic [31:0] w_next_pc;
  logic        w_valid;
  logic [31:0] w_instr;

  // Address fetched after the instruction currently being handed off.
  // A live redirect beats a pending one captured during an earlier bubble.
  assign w_next_pc = redirect_valid ? redirect_pc :
                     r_pend_valid   ? r_pend_pc   :
                                      r_pc + 32'd4;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_buf_nxt  = r_instr_buf;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_valid          = 1'b0;
    w_instr          = NOP_INSTR;

    case (r_state)
      S_REQ: begin
        if (imem_rvalid) begin
          // Same-cycle bypass gives one instruction per cycle at zero wait.
          w_valid = 1'b1;
          w_instr = imem_rdata;
          if (en_if) begin
            w_pc_nxt         = w_next_pc;
            w_pend_valid_nxt = 1'b0;
          end else begin
            w_instr_buf_nxt = imem_rdata;
            w_state_nxt     = S_HOLD;
          end
        end else if (en_if && redirect_valid) begin
          // Branch leaves ID with a bubble behind it; the instruction still
          // in flight is its delay slot, so remember the target for later.
          w_pend_valid_nxt = 1'b1;
          w_pend_pc_nxt    = redirect_pc;
        end
      end
      S_HOLD: begin
        w_valid = 1'b1;
        w_instr = r_instr_buf;
        if (en_if) begin
          w_pc_nxt         = w_next_pc;
          w_pend_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    if (reset) begin
      w_valid = 1'b0;
      w_instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_instr_buf  <= NOP_INSTR;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr_buf  <= w_instr_buf_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
    end
  end

  assign imem_req  = (r_state == S_REQ) && !reset;
  assign imem_addr = r_pc;
  assign pc_if     = r_pc;
  assign pc4_if    = r_pc + 32'd4;
  assign valid_if  = w_valid;
  assign instr_if  = w_instr;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit. Directed per-cycle vector
//            table for the fetch/stall/redirect/reset corner cases, followed
//            by randomized traffic compared against a transaction-level model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_if;
  logic [31:0] pc4_if;
  logic [31:0] pc_if;
  logic        valid_if;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  if_fetch_unit #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en_if          (en_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_if       (instr_if),
    .pc4_if         (pc4_if),
    .pc_if          (pc_if),
    .valid_if       (valid_if)
  );

  always #5 clk = ~clk;

  // Instruction memory: answers after mem_lat waiting cycles; word = ~addr.
  int unsigned mem_cnt = 0;
  int unsigned mem_lat = 0;
  assign imem_rvalid = imem_req && (mem_cnt >= mem_lat);
  assign imem_rdata  = ~imem_addr;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_rvalid) mem_cnt <= 0;
    else                                   mem_cnt <= mem_cnt + 1;
  end

  // Transaction-level model: the address being fetched, whether its word has
  // arrived, and the latest branch target seen by an enabled IF/ID since the
  // last delivered instruction.
  logic [31:0] m_pc = C_RESET_PC;
  logic        m_got = 1'b0;
  logic        m_tgt_v = 1'b0;
  logic [31:0] m_tgt = 32'd0;
  logic        m_rv, m_v, m_ho, m_tv;
  logic [31:0] m_tn;

  assign m_rv = !reset && !m_got && (mem_cnt >= mem_lat);
  assign m_v  = !reset && (m_got || m_rv);
  assign m_ho = en_if && m_v;
  assign m_tv = (en_if && redirect_valid) || m_tgt_v;
  assign m_tn = (en_if && redirect_valid) ? redirect_pc : m_tgt;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= C_RESET_PC;
      m_got   <= 1'b0;
      m_tgt_v <= 1'b0;
      m_tgt   <= 32'd0;
    end else begin
      m_got   <= m_v && !m_ho;
      m_tgt_v <= m_tv && !m_ho;
      m_tgt   <= m_tn;
      if (m_ho) m_pc <= m_tv ? m_tn : m_pc + 32'd4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    int unsigned lat;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic en, input logic rv, input logic [31:0] rpc,
                     input int unsigned lat, input logic e_req, input logic e_valid,
                     input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.rv = rv; v.rpc = rpc; v.lat = lat;
    v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc;
    vt.push_back(v);
  endtask

  initial begin
    reset = 1'b1; en_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    //   rst en rv rpc            lat req val pc
    // zero-wait streaming after reset
    add(1, 1, 0, 32'h0,          0, 0, 0, 32'h3000);
    add(1, 1, 0, 32'h0,          0, 0, 0, 32'h3000);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3000);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3004);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3008);
    // two-cycle wait, handoff on third cycle
    add(0, 1, 0, 32'h0,          2, 1, 0, 32'h300C);
    add(0, 1, 0, 32'h0,          2, 1, 0, 32'h300C);
    add(0, 1, 0, 32'h0,          2, 1, 1, 32'h300C);
    // stall three cycles with data valid, then release
    add(0, 0, 0, 32'h0,          0, 1, 1, 32'h3010);
    add(0, 0, 0, 32'h0,          0, 0, 1, 32'h3010);
    add(0, 0, 0, 32'h0,          0, 0, 1, 32'h3010);
    add(0, 1, 0, 32'h0,          0, 0, 1, 32'h3010);
    // redirect with a valid delay slot
    add(0, 1, 1, 32'h3100,       0, 1, 1, 32'h3014);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3100);
    // redirect during a three-cycle wait: pending target after delay slot
    add(0, 1, 1, 32'h3200,       3, 1, 0, 32'h3104);
    add(0, 1, 0, 32'h0,          3, 1, 0, 32'h3104);
    add(0, 1, 0, 32'h0,          3, 1, 0, 32'h3104);
    add(0, 1, 0, 32'h0,          3, 1, 1, 32'h3104);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3200);
    // redirect while stalled is not captured
    add(0, 0, 1, 32'h3300,       0, 1, 1, 32'h3204);
    add(0, 1, 0, 32'h0,          0, 0, 1, 32'h3204);
    // pending target overwritten by a later redirect (last wins)
    add(0, 1, 1, 32'h3400,       2, 1, 0, 32'h3208);
    add(0, 1, 1, 32'h3500,       2, 1, 0, 32'h3208);
    add(0, 1, 0, 32'h0,          2, 1, 1, 32'h3208);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3500);
    // handoff with both pending and live redirect: live wins, pending clears
    add(0, 1, 1, 32'h3600,       1, 1, 0, 32'h3504);
    add(0, 1, 1, 32'h3700,       1, 1, 1, 32'h3504);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3700);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3704);
    // reset mid-wait with a pending target, which must be discarded
    add(0, 1, 1, 32'h3800,       5, 1, 0, 32'h3708);
    add(1, 1, 0, 32'h0,          5, 0, 0, 32'h3708);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3000);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h3004);
    // pc4 wraps at the top of the address space
    add(0, 1, 1, 32'hFFFF_FFFC,  0, 1, 1, 32'h3008);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,          0, 1, 1, 32'h0000_0000);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      reset = vt[i].rst; en_if = vt[i].en; redirect_valid = vt[i].rv;
      redirect_pc = vt[i].rpc; mem_lat = vt[i].lat;
      @(negedge clk);
      chk($sformatf("v%0d req", i),   {31'd0, imem_req}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d valid", i), {31'd0, valid_if}, {31'd0, vt[i].e_valid});
      chk($sformatf("v%0d instr", i), instr_if, vt[i].e_valid ? ~vt[i].e_pc : C_NOP);
      chk($sformatf("v%0d pc", i),    pc_if, vt[i].e_pc);
      chk($sformatf("v%0d addr", i),  imem_addr, vt[i].e_pc);
      chk($sformatf("v%0d pc4", i),   pc4_if, vt[i].e_pc + 32'd4);
    end

    // randomized traffic against the model
    @(posedge clk); #1; reset = 1'b1; en_if = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset          = ($urandom_range(0, 199) == 0);
      en_if          = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 15);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      mem_lat        = $urandom_range(0, 3);
      @(negedge clk);
      chk($sformatf("r%0d req", c),   {31'd0, imem_req}, {31'd0, !reset && !m_got});
      chk($sformatf("r%0d valid", c), {31'd0, valid_if}, {31'd0, m_v});
      chk($sformatf("r%0d instr", c), instr_if, m_v ? ~m_pc : C_NOP);
      chk($sformatf("r%0d pc", c),    pc_if, m_pc);
      chk($sformatf("r%0d addr", c),  imem_addr, m_pc);
      chk($sformatf("r%0d pc4", c),   pc4_if, m_pc + 32'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
